// File: rtl/iter_shift_unit_if.sv
// Start/done handshake bundle for iter_shift_unit: operand, distance and mode in, status and result out.
`timescale 1ns/1ps
interface iter_shift_unit_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               start;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         mode;
    logic               ready;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, data_in, shamt, mode,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, data_in, shamt, mode,
        output ready, busy, done, result
    );
endinterface

// File: rtl/iter_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter resolving one shift-amount bit per cycle, MSB first.
// Optional macro ITER_SHIFT_EARLY_EXIT_EN: finish as soon as the remaining shift-amount bits are zero.
`timescale 1ns/1ps
module iter_shift_unit #(
    parameter int WIDTH = 32
) (
    input logic               clock,
    input logic               reset,
    iter_shift_unit_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] k_q, k_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [SHAMT_W-1:0] stage_dist;
    logic [2*WIDTH-1:0] ror_wide;
    logic [WIDTH-1:0]   stage_out;
    logic [WIDTH-1:0]   work_next;
    logic               last_stage;

    // The single reusable stage: shift the working value by 2^k in the captured mode.
    always_comb begin
        stage_dist = SHAMT_W'(1) << k_q;
        ror_wide   = {work_q, work_q} >> stage_dist;
        case (mode_q)
            MODE_SLL: stage_out = work_q << stage_dist;
            MODE_SRL: stage_out = work_q >> stage_dist;
            MODE_SRA: stage_out = $signed(work_q) >>> stage_dist;
            default:  stage_out = ror_wide[WIDTH-1:0];
        endcase
        work_next = shamt_q[k_q] ? stage_out : work_q;
    end

`ifdef ITER_SHIFT_EARLY_EXIT_EN
    logic [SHAMT_W-1:0] low_mask;

    always_comb begin
        low_mask   = (SHAMT_W'(1) << k_q) - SHAMT_W'(1);
        last_stage = ((shamt_q & low_mask) == '0);
    end
`else
    always_comb begin
        last_stage = (k_q == '0);
    end
`endif

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        k_d      = k_q;
        shamt_d  = shamt_q;
        mode_d   = mode_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    work_d  = bus.data_in;
                    shamt_d = bus.shamt;
                    mode_d  = bus.mode;
                    k_d     = SHAMT_W'(SHAMT_W - 1);
                    state_d = ST_SHIFT;
`ifdef ITER_SHIFT_EARLY_EXIT_EN
                    if (bus.shamt == '0) begin
                        result_d = bus.data_in;
                        state_d  = ST_DONE;
                    end
`endif
                end
            end
            ST_SHIFT: begin
                work_d = work_next;
                k_d    = k_q - SHAMT_W'(1);
                if (last_stage) begin
                    result_d = work_next;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            k_q      <= '0;
            shamt_q  <= '0;
            mode_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            k_q      <= k_d;
            shamt_q  <= shamt_d;
            mode_q   <= mode_d;
            result_q <= result_d;
        end
    end

    assign bus.ready  = (state_q == ST_IDLE);
    assign bus.busy   = (state_q == ST_SHIFT);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench for iter_shift_unit: stimulus pushes model results and done cycles, a monitor pops on done.
`timescale 1ns/1ps
module tb_iter_shift_unit;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = $clog2(WIDTH);

    typedef struct {
        logic [WIDTH-1:0] res;
        int               cyc;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];

    iter_shift_unit_if #(.WIDTH(WIDTH)) bus ();

    iter_shift_unit #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    // Reference model: the whole shift applied at once from the mode definitions.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] m, input logic [WIDTH-1:0] d, input int s);
        logic [2*WIDTH-1:0] w;
        case (m)
            2'b00: return d << s;
            2'b01: return d >> s;
            2'b10: begin
                w = {{WIDTH{d[WIDTH-1]}}, d} >> s;
                return w[WIDTH-1:0];
            end
            default: begin
                w = {d, d} >> s;
                return w[WIDTH-1:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input int s);
`ifdef ITER_SHIFT_EARLY_EXIT_EN
        if (s == 0) return 1;
        for (int b = 0; b < SHAMT_W; b++) begin
            if (s[b]) return SHAMT_W - b + 1;
        end
        return 1;
`else
        return SHAMT_W + 1 + (s & 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Issue one request as soon as the unit is ready; returns the cycle start was driven in.
    task automatic apply_stimulus(input logic [1:0] m, input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                                  output int start_cyc, output int lat);
        int   waited;
        exp_t e;
        waited = 0;
        while (!bus.ready && waited < 100) begin
            tick();
            waited++;
        end
        lat = ref_latency(int'(s));
        start_cyc = cyc;
        if (!bus.ready) begin
            n_checks++;
            $display("[TB] FAIL ready_timeout: ready stuck low, expected high within 100 cycles");
            return;
        end
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.shamt   = s;
        bus.mode    = m;
        e.res = ref_shift(m, d, int'(s));
        e.cyc = cyc + lat;
        exp_q.push_back(e);
        tick();
        bus.start = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_done: got done=1 with result %h, expected no done (cycle %0d)", bus.result, cyc);
            end else begin
                e = exp_q.pop_front();
                check_output("result", bus.result, e.res);
                check_output("done_cycle", WIDTH'(cyc), WIDTH'(e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c, lat, c2, lat2;
        logic [WIDTH-1:0] first_res;
        int waited;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = '0;
        bus.shamt   = '0;
        bus.mode    = '0;
        n_checks    = 0;
        n_pass      = 0;
        tick();
        bus.start = 1'b1;
        bus.data_in = 32'hCAFEF00D;
        tick();
        check_output("reset_ready", WIDTH'(bus.ready), 1);
        check_output("reset_busy", WIDTH'(bus.busy), 0);
        check_output("reset_done", WIDTH'(bus.done), 0);
        check_output("reset_result", bus.result, 0);
        bus.start = 1'b0;
        reset = 1'b0;
        tick();

        // SRA with a full busy/ready trace around the operation.
        apply_stimulus(2'b10, 32'h80000000, 5'd16, c, lat);
        for (int i = 1; i <= lat + 1; i++) begin
            check_output("trace_busy", WIDTH'(bus.busy), WIDTH'(i < lat));
            check_output("trace_ready", WIDTH'(bus.ready), WIDTH'(i == lat + 1));
            if (i < lat + 1) tick();
        end

        apply_stimulus(2'b01, 32'h80000000, 5'd16, c, lat);
        apply_stimulus(2'b00, 32'h00000001, 5'd31, c, lat);
        apply_stimulus(2'b11, 32'h00000001, 5'd1,  c, lat);
        apply_stimulus(2'b10, 32'h7FFFFFFF, 5'd31, c, lat);
        apply_stimulus(2'b10, 32'hDEADBEEF, 5'd0,  c, lat);
        apply_stimulus(2'b11, 32'h80000001, 5'd31, c, lat);

        // Starts during SHIFT and DONE must be ignored.
        apply_stimulus(2'b01, 32'hFFFF0000, 5'd8, c, lat);
        for (int i = 1; i <= lat + 1; i++) begin
            if (i == 2 || i == lat) begin
                bus.start   = 1'b1;
                bus.data_in = 32'h0BADF00D;
                bus.shamt   = 5'd3;
                bus.mode    = 2'b00;
            end else begin
                bus.start = 1'b0;
            end
            if (i == lat + 1) check_output("ignored_start_ready", WIDTH'(bus.ready), 1);
            if (i < lat + 1) tick();
        end
        bus.start = 1'b0;
        tick();
        check_output("ignored_start_no_capture", WIDTH'(bus.busy), 0);

        // Reset mid-operation aborts without a done pulse.
        apply_stimulus(2'b00, 32'h12345678, 5'd0, c, lat);
        apply_stimulus(2'b01, 32'hA5A5A5A5, 5'h11, c, lat);
        tick();
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        check_output("abort_ready", WIDTH'(bus.ready), 1);
        check_output("abort_result", bus.result, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_output("abort_no_done", WIDTH'(bus.done), 0);
            tick();
        end

        // Back-to-back: result holds the first value until the second completes.
        apply_stimulus(2'b11, 32'h12345678, 5'd4, c, lat);
        first_res = ref_shift(2'b11, 32'h12345678, 4);
        apply_stimulus(2'b10, 32'h87654321, 5'd7, c2, lat2);
        check_output("b2b_spacing", WIDTH'(c2 - c), WIDTH'(lat + 1));
        check_output("b2b_result_hold", bus.result, first_res);

        // Randomised operations with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            apply_stimulus(2'($urandom_range(0, 3)), 32'($urandom), 5'($urandom_range(0, 31)), c, lat);
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            tick();
            waited++;
        end
        check_output("drain_outstanding", WIDTH'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
